axis_fifo_ctrl: RTL and testbench

Parametrised AXI-Stream FIFO: the next generation of the team's stream buffer. It replaces raw push/pop strobes with valid/ready handshakes on both sides and carries a `last` sideband bit. It also adds an occupancy count with almost-full/almost-empty flags, and an optional packet (store-and-forward) mode. It sits between an AXI-Stream producer (upstream) and consumer (downstream) in the same clock domain.

---
 rtl/axis_fifo_pkg.sv | 19 +
 rtl/axis_fifo_ptr.sv | 48 ++++
 rtl/axis_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_axis_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared helpers and defaults for the AXI-Stream FIFO slice.
package axis_fifo_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 10;

  // Pointer width; never below one bit, even for tiny depths.
  function automatic int unsigned ptr_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy width; must be able to represent DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_fifo_ptr.sv
// Wrapping FIFO pointer with phase bit; wraps at DEPTH-1 so DEPTH need not be a power of two.
module axis_fifo_ptr
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned PW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  output logic [PW-1:0] ptr,
  output logic          phase
);

  localparam logic [PW-1:0] LastIdx = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          phase_q, phase_d;

  // Next pointer: advance, wrapping to zero and toggling phase at the last entry.
  always_comb begin
    ptr_d   = ptr_q;
    phase_d = phase_q;
    if (adv) begin
      if (ptr_q == LastIdx) begin
        ptr_d   = '0;
        phase_d = ~phase_q;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Pointer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
    end
  end

  assign ptr   = ptr_q;
  assign phase = phase_q;

endmodule

// File: rtl/axis_fifo_ctrl.sv
// AXI-Stream FIFO with valid/ready on both sides, last sideband, occupancy count and
// almost-full/almost-empty flags. Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward:
// downstream is held off until a complete packet is stored (or the FIFO is full).
module axis_fifo_ctrl
  import axis_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned PW = ptr_w(DEPTH),
  localparam int unsigned CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_last,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty
);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_phase, rd_phase;
  logic          empty, full, push, pop;
  logic [CW-1:0] count_q, count_d;

  // Storage holds {last, data}; intentionally not reset.
  logic [WIDTH:0] mem [DEPTH];

  axis_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (push),
    .ptr   (wr_ptr),
    .phase (wr_phase)
  );

  axis_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (pop),
    .ptr   (rd_ptr),
    .phase (rd_phase)
  );

  assign empty    = (wr_ptr == rd_ptr) && (wr_phase == rd_phase);
  assign full     = (wr_ptr == rd_ptr) && (wr_phase != rd_phase);
  assign up_ready = !full;
  assign push     = up_valid && up_ready;
  assign pop      = down_valid && down_ready;

  // Write the accepted beat into the slot under the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {up_last, up_data};
    end
  end

  assign {down_last, down_data} = mem[rd_ptr];

  // Occupancy next-state; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count        = count_q;
  assign almost_full  = 32'(count_q) >= AF_LEVEL;
  assign almost_empty = 32'(count_q) <= AE_LEVEL;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [CW-1:0] pkt_q, pkt_d;
  logic          pkt_in, pkt_out;

  assign pkt_in  = push && up_last;
  assign pkt_out = pop && down_last;

  // Complete-packet count: +1 when a last beat enters, -1 when one leaves.
  always_comb begin
    pkt_d = pkt_q;
    if (pkt_in && !pkt_out) begin
      pkt_d = pkt_q + 1'b1;
    end else if (pkt_out && !pkt_in) begin
      pkt_d = pkt_q - 1'b1;
    end
  end

  // Packet count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  // A full FIFO is released even without a complete packet so oversize packets drain.
  assign down_valid = !empty && ((pkt_q != '0) || full);
`else
  assign down_valid = !empty;
`endif

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Self-checking bench for axis_fifo_ctrl (DEPTH=10 main instance, DEPTH=8 for wrap streaming).
module tb_axis_fifo_ctrl;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up_valid, up_last, down_ready;
  logic [7:0] up_data;

  logic       ur10, dv10, dl10, af10, ae10;
  logic [7:0] dd10;
  logic [3:0] cnt10;
  logic       ur8, dv8, dl8, af8, ae8;
  logic [7:0] dd8;
  logic [3:0] cnt8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_fifo_ctrl #(.WIDTH(8), .DEPTH(10), .AF_LEVEL(8), .AE_LEVEL(2)) dut10 (
    .clk          (clk),
    .rst_n        (rst_n),
    .up_valid     (up_valid),
    .up_ready     (ur10),
    .up_data      (up_data),
    .up_last      (up_last),
    .down_valid   (dv10),
    .down_ready   (down_ready),
    .down_data    (dd10),
    .down_last    (dl10),
    .count        (cnt10),
    .almost_full  (af10),
    .almost_empty (ae10)
  );

  axis_fifo_ctrl #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .up_valid     (up_valid),
    .up_ready     (ur8),
    .up_data      (up_data),
    .up_last      (up_last),
    .down_valid   (dv8),
    .down_ready   (down_ready),
    .down_data    (dd8),
    .down_last    (dl8),
    .count        (cnt8),
    .almost_full  (af8),
    .almost_empty (ae8)
  );

  typedef struct {
    logic       uv;
    logic [7:0] ud;
    logic       ul;
    logic       dr;
    logic       e_ur;
    logic       e_dv;
    logic [7:0] e_dd;
    logic       e_dl;
    logic [3:0] e_cnt;
    logic       e_af;
    logic       e_ae;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    up_valid   = 1'b0;
    up_data    = 8'h00;
    up_last    = 1'b0;
    down_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Safety net against an accidental hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;

    // Fill 0x01..0x0A with consumer stalled; the tenth beat carries last.
    for (int i = 0; i < 10; i++) begin
      v.uv = 1'b1; v.ud = 8'(i + 1); v.ul = (i == 9); v.dr = 1'b0;
      v.e_ur = 1'b1; v.e_dv = PKT ? 1'b0 : (i > 0); v.e_dd = 8'h01; v.e_dl = 1'b0;
      v.e_cnt = 4'(i); v.e_af = (i >= 8); v.e_ae = (i <= 2);
      vecs.push_back(v);
    end
    // Push and pop together while full: pop wins, push stalls.
    v.uv = 1'b1; v.ud = 8'h0B; v.ul = 1'b0; v.dr = 1'b1;
    v.e_ur = 1'b0; v.e_dv = 1'b1; v.e_dd = 8'h01; v.e_dl = 1'b0;
    v.e_cnt = 4'd10; v.e_af = 1'b1; v.e_ae = 1'b0;
    vecs.push_back(v);
    // Drain the remaining nine beats.
    for (int k = 1; k < 10; k++) begin
      v.uv = 1'b0; v.ud = 8'h00; v.ul = 1'b0; v.dr = 1'b1;
      v.e_ur = 1'b1; v.e_dv = 1'b1; v.e_dd = 8'(k + 1); v.e_dl = (k == 9);
      v.e_cnt = 4'(10 - k); v.e_af = ((10 - k) >= 8); v.e_ae = ((10 - k) <= 2);
      vecs.push_back(v);
    end
    v.uv = 1'b0; v.ud = 8'h00; v.ul = 1'b0; v.dr = 1'b0;
    v.e_ur = 1'b1; v.e_dv = 1'b0; v.e_dd = 8'h00; v.e_dl = 1'b0;
    v.e_cnt = 4'd0; v.e_af = 1'b0; v.e_ae = 1'b1;
    vecs.push_back(v);

    // Reset and idle outputs.
    do_reset();
    #1;
    check("rst_up_ready", 32'(ur10), 32'd1);
    check("rst_down_valid", 32'(dv10), 32'd0);
    check("rst_count", 32'(cnt10), 32'd0);
    check("rst_almost_empty", 32'(ae10), 32'd1);
    check("rst_almost_full", 32'(af10), 32'd0);

    // Table-driven fill / full-collision / drain with thresholds.
    foreach (vecs[n]) begin
      @(negedge clk);
      up_valid = vecs[n].uv; up_data = vecs[n].ud; up_last = vecs[n].ul;
      down_ready = vecs[n].dr;
      #1;
      check($sformatf("vec%0d_up_ready", n), 32'(ur10), 32'(vecs[n].e_ur));
      check($sformatf("vec%0d_down_valid", n), 32'(dv10), 32'(vecs[n].e_dv));
      check($sformatf("vec%0d_count", n), 32'(cnt10), 32'(vecs[n].e_cnt));
      check($sformatf("vec%0d_almost_full", n), 32'(af10), 32'(vecs[n].e_af));
      check($sformatf("vec%0d_almost_empty", n), 32'(ae10), 32'(vecs[n].e_ae));
      if (vecs[n].e_dv) begin
        check($sformatf("vec%0d_down_data", n), 32'(dd10), 32'(vecs[n].e_dd));
        check($sformatf("vec%0d_down_last", n), 32'(dl10), 32'(vecs[n].e_dl));
      end
    end

    // Continuous push/pop for 25 beats on both depths; every beat is its own packet.
    do_reset();
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      up_valid = (k < 25); up_data = 8'(k + 1); up_last = 1'b1; down_ready = (k > 0);
      #1;
      check($sformatf("stream%0d_count10", k), 32'(cnt10), (k == 0) ? 32'd0 : 32'd1);
      check($sformatf("stream%0d_count8", k), 32'(cnt8), (k == 0) ? 32'd0 : 32'd1);
      if (k > 0) begin
        check($sformatf("stream%0d_data10", k), 32'(dd10), 32'(k));
        check($sformatf("stream%0d_data8", k), 32'(dd8), 32'(k));
        check($sformatf("stream%0d_valid8", k), 32'(dv8), 32'd1);
      end
    end
    @(negedge clk);
    up_valid = 1'b0; down_ready = 1'b0;
    #1;
    check("stream_end_count10", 32'(cnt10), 32'd0);
    check("stream_end_count8", 32'(cnt8), 32'd0);

    // Three-beat packet, last on the third beat, consumer stalled.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      up_valid = 1'b1; up_data = 8'(8'h10 + b); up_last = (b == 2); down_ready = 1'b0;
      #1;
      check($sformatf("pkt3_b%0d_down_valid", b), 32'(dv10), (PKT ? 1'b0 : (b > 0)) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    up_valid = 1'b0;
    #1;
    check("pkt3_done_down_valid", 32'(dv10), 32'd1);
    check("pkt3_done_count", 32'(cnt10), 32'd3);
    check("pkt3_done_data", 32'(dd10), 32'h10);

    // Ten beats without last: released once full.
    do_reset();
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      up_valid = 1'b1; up_data = 8'(8'h20 + b); up_last = 1'b0; down_ready = 1'b0;
      #1;
      check($sformatf("nolast_b%0d_down_valid", b), 32'(dv10), (PKT ? 1'b0 : (b > 0)) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    up_valid = 1'b0; down_ready = 1'b1;
    #1;
    check("nolast_full_down_valid", 32'(dv10), 32'd1);
    check("nolast_full_up_ready", 32'(ur10), 32'd0);
    check("nolast_full_count", 32'(cnt10), 32'd10);
    @(negedge clk);
    down_ready = 1'b0;
    #1;
    check("nolast_pop1_count", 32'(cnt10), 32'd9);
    check("nolast_pop1_up_ready", 32'(ur10), 32'd1);
    check("nolast_pop1_down_valid", 32'(dv10), PKT ? 32'd0 : 32'd1);
    check("nolast_pop1_data", 32'(dd10), 32'h21);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      up_valid = 1'b1; up_data = 8'(8'h30 + b); up_last = 1'b0; down_ready = 1'b0;
    end
    @(negedge clk);
    up_valid = 1'b0;
    #1;
    check("midrst_pre_count", 32'(cnt10), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", 32'(cnt10), 32'd0);
    check("midrst_down_valid", 32'(dv10), 32'd0);
    check("midrst_up_ready", 32'(ur10), 32'd1);
    check("midrst_almost_empty", 32'(ae10), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_after_count", 32'(cnt10), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
